// File: rtl/receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// one-entry holding register with framing-error and overrun pulses.
module receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_in,
    input  logic       rx_data_ready,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_framing_err,
    output logic       rx_overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic          sync1;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_serial_in;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            rx_data        <= '0;
            rx_data_valid  <= 1'b0;
            rx_framing_err <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_framing_err <= 1'b0;
            rx_overrun     <= 1'b0;
            // A host transfer frees the register; a coinciding delivery reloads it below.
            if (rx_data_valid && rx_data_ready)
                rx_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            if (!rx_data_valid || rx_data_ready) begin
                                rx_data       <= shreg;
                                rx_data_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            rx_framing_err <= 1'b1;
                            state          <= BRK;
                        end
                    end
                end
                BRK: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for receiver: frames driven at 16 cycles/bit,
// expected bytes and edge timing computed by hand.
module tb_receiver;

    logic       clk;
    logic       rst_n;
    logic       rx_serial_in;
    logic       rx_data_ready;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_framing_err;
    logic       rx_overrun;

    receiver #(.OVERSAMPLE(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_serial_in   (rx_serial_in),
        .rx_data_ready  (rx_data_ready),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_framing_err (rx_framing_err),
        .rx_overrun     (rx_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int t0;

    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    logic       pv = 1'b0;

    always @(negedge clk) begin
        if (rx_data_valid && !pv) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(rx_data);
        end
        pv = rx_data_valid;
        if (rx_framing_err) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        rise_cyc.delete();
        rise_dat.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Returns one cycle before the frame ends so frames chain with no gap.
    task automatic send(input logic [7:0] b, input logic stp);
        @(posedge clk);
        #2 rx_serial_in = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk);
            #2 rx_serial_in = b[i];
        end
        repeat (16) @(posedge clk);
        #2 rx_serial_in = stp;
        repeat (15) @(posedge clk);
    endtask

    int ts;
    logic [7:0] v99;

    initial begin
        rst_n         = 1'b0;
        rx_serial_in  = 1'b1;
        rx_data_ready = 1'b1;
        #22;
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_data_valid, 0);
        chk("rst_ferr", rx_framing_err, 0);
        chk("rst_ovr", rx_overrun, 0);
        #5 rst_n = 1'b1;
        idle(10);

        clr();
        send(8'hA5, 1'b1);
        ts = t0;
        idle(20);
        chk("a5_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) begin
            chk("a5_data", rise_dat[0], 8'hA5);
            chk("a5_latency", rise_cyc[0] - ts, 155);
        end
        chk("a5_onecycle", rx_data_valid, 0);
        chk("a5_ferr", ferr_cnt, 0);
        chk("a5_ovr", ovr_cnt, 0);

        clr();
        send(8'h00, 1'b1);
        ts = t0;
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        idle(20);
        chk("b2b_count", rise_cyc.size(), 3);
        if (rise_cyc.size() == 3) begin
            chk("b2b_d0", rise_dat[0], 8'h00);
            chk("b2b_d1", rise_dat[1], 8'hFF);
            chk("b2b_d2", rise_dat[2], 8'h3C);
            chk("b2b_t0", rise_cyc[0] - ts, 155);
            chk("b2b_gap1", rise_cyc[1] - rise_cyc[0], 160);
            chk("b2b_gap2", rise_cyc[2] - rise_cyc[1], 160);
        end
        chk("b2b_ferr", ferr_cnt, 0);

        clr();
        @(posedge clk);
        #2 rx_serial_in = 1'b0;
        idle(3);
        #2 rx_serial_in = 1'b1;
        idle(30);
        chk("glitch_none", rise_cyc.size(), 0);
        chk("glitch_ferr", ferr_cnt, 0);
        send(8'h5A, 1'b1);
        idle(20);
        chk("5a_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) chk("5a_data", rise_dat[0], 8'h5A);

        clr();
        send(8'h81, 1'b0);
        idle(40);
        #2 rx_serial_in = 1'b1;
        idle(20);
        chk("brk_ferr", ferr_cnt, 1);
        chk("brk_novalid", rise_cyc.size(), 0);
        send(8'h42, 1'b1);
        idle(20);
        chk("42_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) chk("42_data", rise_dat[0], 8'h42);
        chk("42_ferr", ferr_cnt, 1);

        clr();
        rx_data_ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        idle(20);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_data_valid, 1);
        chk("ovr_pulse", ovr_cnt, 1);
        @(posedge clk);
        #2 rx_data_ready = 1'b1;
        @(posedge clk);
        #2 rx_data_ready = 1'b0;
        chk("ovr_consumed", rx_data_valid, 0);

        clr();
        send(8'h11, 1'b1);
        fork
            send(8'h22, 1'b1);
            begin
                @(posedge clk);
                #3;
                repeat (154) @(posedge clk);
                #2 rx_data_ready = 1'b1;
                chk("sim_pre_data", rx_data, 8'h11);
                @(posedge clk);
                #1;
                chk("sim_data", rx_data, 8'h22);
                chk("sim_valid", rx_data_valid, 1);
                #1 rx_data_ready = 1'b0;
            end
        join
        idle(20);
        chk("sim_ovr", ovr_cnt, 0);
        chk("sim_hold", rx_data, 8'h22);
        chk("sim_hold_v", rx_data_valid, 1);

        v99 = 8'h99;
        @(posedge clk);
        #2 rx_serial_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (16) @(posedge clk);
            #2 rx_serial_in = v99[i];
        end
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", rx_data, 0);
        chk("arst_valid", rx_data_valid, 0);
        chk("arst_ferr", rx_framing_err, 0);
        chk("arst_ovr", rx_overrun, 0);
        rx_serial_in  = 1'b1;
        rx_data_ready = 1'b1;
        idle(3);
        #2 rst_n = 1'b1;
        idle(30);
        clr();
        send(8'hC3, 1'b1);
        idle(20);
        chk("c3_count", rise_cyc.size(), 1);
        if (rise_cyc.size() >= 1) chk("c3_data", rise_dat[0], 8'hC3);
        chk("c3_ferr", ferr_cnt, 0);
        chk("c3_ovr", ovr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
